// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared state encoding, seed patterns and field widths for the LED sequencer.
package led_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10} state_t;
  localparam int SPEED_W = 2;
  localparam int PAT_W = 2;
  localparam logic [7:0] SEED [0:3] = '{8'h01, 8'h03, 8'h55, 8'h0F};
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer, stability-count debouncer and rising-edge press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
  logic s0, s1, db, db_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      press <= 1'b0;
      cnt <= '0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
      db_q <= db;
      press <= db && !db_q;
      cnt <= (s1 == db || cnt == LAST) ? '0 : cnt + 1'b1;
      if (s1 != db && cnt == LAST) db <= s1;
    end
endmodule

// File: rtl/led_sequence_controller.sv
// led_sequence_controller: button-driven run/pause/stop sequencer for an 8-bit rotating LED bank.
module led_sequence_controller
  import led_seq_pkg::*;
#(
  parameter int TICK_BASE = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         btn_dir,
  input  logic         btn_speed,
  input  logic         btn_pattern,
  output logic [7:0]   led,
  output logic [1:0]   state,
  output logic [SPEED_W-1:0] speed,
  output logic         dir
);
  localparam int CW = $clog2(TICK_BASE);
  logic [4:0] raw, press;
  logic p_start, p_stop, p_dir, p_speed, p_pat;
  state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n, last;
  logic [7:0] led_n, rot;
  logic [SPEED_W-1:0] speed_n;
  logic [PAT_W-1:0] pat, pat_n;
  logic dir_n, run, idle, wrap;
  assign raw = {btn_pattern, btn_speed, btn_dir, btn_stop, btn_start};
  assign {p_pat, p_speed, p_dir, p_stop, p_start} = press;
  genvar b;
  for (b = 0; b < 5; b++) begin : db
    button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst(rst), .btn_raw(raw[b]), .press(press[b])
    );
  end
  assign state = st;
  assign run = st == RUN;
  assign idle = !(run || st == PAUSE);
  assign last = CW'((TICK_BASE >> speed) - 1);
  // A speed press restarts the period, so it also suppresses a step due on the same edge.
  assign wrap = run && cnt == last && !p_speed;
  assign rot = dir ? {led[0], led[7:1]} : {led[6:0], led[7]};
  always_comb begin
    st_n = idle ? IDLE : st;
    cnt_n = run ? (wrap ? '0 : cnt + 1'b1) : (idle ? '0 : cnt);
    led_n = wrap ? rot : led;
    speed_n = speed;
    dir_n = dir;
    pat_n = pat;
    if (p_stop) begin
      st_n = IDLE;
      led_n = SEED[pat];
      cnt_n = '0;
    end else begin
      if (p_start) st_n = run ? PAUSE : RUN;
      if (p_pat && idle) begin
        pat_n = pat + 2'd1;
        led_n = SEED[pat_n];
      end
      if (p_dir) dir_n = !dir;
      if (p_speed) begin
        speed_n = speed + 2'd1;
        cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      led <= SEED[0];
      speed <= '0;
      dir <= 1'b0;
      pat <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      led <= led_n;
      speed <= speed_n;
      dir <= dir_n;
      pat <= pat_n;
    end
endmodule

// File: tb/tb_led_sequence_controller.sv
// tb_led_sequence_controller: directed scenarios plus random button traffic against a cycle-level reference model.
module tb_led_sequence_controller;
  localparam int TB = 16;
  localparam int D = 4;
  localparam int START = 0, STOP = 1, DIR = 2, SPEED = 3, PAT = 4;
  localparam bit [31:0] MASK = (32'd1 << D) - 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] btn = '0;
  logic [7:0] led;
  logic [1:0] state, speed;
  logic dir;
  int checks = 0, fails = 0;
  bit chk_on = 1'b0;
  logic [7:0] frozen;

  led_sequence_controller #(.TICK_BASE(TB), .DEBOUNCE_CYC(D)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn[START]), .btn_stop(btn[STOP]), .btn_dir(btn[DIR]),
    .btn_speed(btn[SPEED]), .btn_pattern(btn[PAT]),
    .led(led), .state(state), .speed(speed), .dir(dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seed(int p);
    return p == 0 ? 8'h01 : p == 1 ? 8'h03 : p == 2 ? 8'h55 : 8'h0F;
  endfunction

  function automatic logic [7:0] rot(logic [7:0] v, bit d);
    int x = v;
    return 8'(d ? (x >> 1) | (x << 7) : (x << 1) | (x >> 7));
  endfunction

  // Reference model: edge-indexed, press scheduled by timestamp once D agreeing samples are seen
  int n = 0, m_state = 0, m_cnt = 0, m_speed = 0, m_pat = 0;
  bit m_dir = 1'b0;
  logic [7:0] m_led = 8'h01;
  bit d1[5], d2[5], acc[5];
  bit [31:0] win[5];
  int due[5] = '{-1, -1, -1, -1, -1};

  always @(posedge clk or negedge rst) begin : model
    bit pr[5];
    bit s;
    int p, prev;
    if (!rst) begin
      m_state = 0; m_cnt = 0; m_speed = 0; m_pat = 0; m_dir = 1'b0; m_led = 8'h01;
      for (int b = 0; b < 5; b++) begin
        d1[b] = 1'b0; d2[b] = 1'b0; acc[b] = 1'b0; win[b] = '0; due[b] = -1;
      end
    end else begin
      n++;
      for (int b = 0; b < 5; b++) begin
        pr[b] = due[b] == n;
        if (pr[b]) due[b] = -1;
        s = d2[b];
        d2[b] = d1[b];
        d1[b] = btn[b];
        win[b] = {win[b][30:0], s};
        if ((win[b] & MASK) == (acc[b] ? 32'd0 : MASK)) begin
          acc[b] = !acc[b];
          if (acc[b]) due[b] = n + 2;
        end
      end
      p = TB >> m_speed;
      prev = m_state;
      if (pr[STOP]) begin
        m_state = 0; m_led = seed(m_pat); m_cnt = 0;
      end else begin
        if (pr[SPEED]) begin
          m_speed = (m_speed + 1) % 4; m_cnt = 0;
        end else if (prev == 1) begin
          m_cnt = (m_cnt + 1) % p;
          if (m_cnt == 0) m_led = rot(m_led, m_dir);
        end
        if (pr[START]) m_state = prev == 1 ? 2 : 1;
        if (pr[PAT] && prev == 0) begin
          m_pat = (m_pat + 1) % 4; m_led = seed(m_pat);
        end
        if (pr[DIR]) m_dir = !m_dir;
      end
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      check("led", led, m_led);
      check("state", state, m_state);
      check("speed", speed, m_speed);
      check("dir", dir, m_dir);
      check("cnt", dut.cnt, m_cnt);
    end

  task automatic tick(input int k);
    repeat (k) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold(input int b, input int len);
    btn[b] = 1'b1;
    tick(len);
    btn[b] = 1'b0;
  endtask

  task automatic press(input int b, input int len);
    hold(b, len);
    tick(8);
  endtask

  initial begin
    tick(2);
    rst = 1'b1;
    chk_on = 1'b1;
    check("rst_led", led, 8'h01);
    check("rst_state", state, 0);
    check("rst_speed", speed, 0);
    check("rst_dir", dir, 0);
    // basic run and wrap
    hold(START, 8);
    check("run_entry", state, 1);
    tick(15); check("step1_pre", led, 8'h01);
    tick(1);  check("step1", led, 8'h02);
    tick(16); check("step2", led, 8'h04);
    tick(95); check("step7", led, 8'h80);
    tick(1);  check("wrap8", led, 8'h01);
    // debounce and speed
    press(STOP, 8); check("stop_idle", state, 0);
    hold(SPEED, 3); tick(12); check("glitch_speed", speed, 0);
    hold(SPEED, 10); check("speed1", speed, 1); tick(8);
    hold(START, 8);
    tick(7); check("fast_pre", led, 8'h01);
    tick(1); check("fast_step", led, 8'h02);
    tick(8); check("fast_step2", led, 8'h04);
    for (int i = 0; i < 3; i++) press(SPEED, 8);
    check("speed_wrap", speed, 0);
    // pattern select and direction
    press(STOP, 8);
    press(PAT, 8); press(PAT, 8);
    check("pat55", led, 8'h55); check("pat_idx", dut.pat, 2);
    press(DIR, 8); check("dir1", dir, 1);
    press(START, 8);
    tick(7); check("aa_pre", led, 8'h55);
    tick(1); check("aa", led, 8'hAA);
    press(PAT, 8); check("pat_run_idx", dut.pat, 2); check("pat_run_state", state, 1);
    // pause with the counter retained at 5, then resume
    for (int i = 0; i < 40 && m_cnt != 13; i++) tick(1);
    hold(START, 8);
    check("paused", state, 2); check("pause_cnt", dut.cnt, 5);
    frozen = m_led;
    tick(200); check("frozen", led, frozen);
    hold(START, 8); check("resumed", state, 1);
    tick(10); check("resume_pre", led, frozen);
    tick(1);  check("resume_step", led, rot(frozen, 1'b1));
    press(SPEED, 8); check("speed_run", speed, 1);
    // stop and start together
    tick(3);
    btn[START] = 1'b1; btn[STOP] = 1'b1;
    tick(8);
    btn = '0;
    check("both_state", state, 0); check("both_led", led, 8'h55);
    check("both_cnt", dut.cnt, 0); check("both_speed", speed, 1); check("both_dir", dir, 1);
    tick(8);
    // async reset mid-run with a button held through it
    press(PAT, 8); press(PAT, 8); press(SPEED, 8); press(START, 8);
    for (int i = 0; i < 100 && m_led != 8'h08; i++) tick(1);
    check("pre_rst_led", led, 8'h08); check("pre_rst_speed", speed, 2);
    btn[SPEED] = 1'b1;
    rst = 1'b0;
    #1;
    check("arst_led", led, 8'h01); check("arst_state", state, 0);
    check("arst_speed", speed, 0); check("arst_dir", dir, 0);
    tick(1);
    rst = 1'b1;
    tick(6); check("held_nopress", speed, 0);
    tick(2); check("held_press", speed, 1);
    btn[SPEED] = 1'b0;
    tick(10);
    // random traffic
    for (int it = 0; it < 300; it++) begin
      int r, b;
      r = $urandom_range(0, 9);
      b = r < 3 ? START : r == 3 ? STOP : r < 6 ? DIR : r < 8 ? SPEED : PAT;
      btn[b] = 1'b1;
      if ($urandom_range(0, 9) == 0) btn[$urandom_range(0, 4)] = 1'b1;
      tick($urandom_range(1, 10));
      btn = '0;
      tick($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
      end
    end
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
